// File: rtl/rca_lsu_arbiter_pkg.sv
// Shared types for the RCA-to-LSU request arbiter.
package rca_lsu_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned FN3_W         = 3;
    localparam int unsigned DEF_NUM_PORTS = 4;

    // Port identifier for the default port count; tag width in the top follows NUM_PORTS.
    typedef logic [$clog2(DEF_NUM_PORTS)-1:0] port_id_t;

    // One memory request as presented by an RCA lane.
    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic [FN3_W-1:0] fn3;
        logic             load;
        logic             store;
    } rca_mem_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2,
        DRAIN   = 2'd3
    } rca_arb_state_t;

endpackage

// File: rtl/rca_lsu_arbiter_if.sv
// Requester-side bus between the RCA lanes and the arbiter.
interface rca_lsu_arbiter_if
    import rca_lsu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0]             req_ready;
    logic [NUM_PORTS-1:0][XLEN-1:0]   req_addr;
    logic [NUM_PORTS-1:0][XLEN-1:0]   req_wdata;
    logic [NUM_PORTS-1:0][FN3_W-1:0]  req_fn3;
    logic [NUM_PORTS-1:0]             req_load;
    logic [NUM_PORTS-1:0]             req_store;
    logic [NUM_PORTS-1:0]             resp_valid;
    logic [XLEN-1:0]                  resp_data;

    modport master (
        output req_valid, req_addr, req_wdata, req_fn3, req_load, req_store,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_fn3, req_load, req_store,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/rca_lsu_arbiter_rr.sv
// Round-robin selector: first requester after ptr, wrapping modulo N.
module rca_rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    int unsigned scan;

    // Scan ptr+1, ptr+2, ... and stop at the first asserted request.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        scan = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            scan = (32'(ptr) + i) % N;
            if (!any && req[PW'(scan)]) begin
                any = 1'b1;
                idx = PW'(scan);
            end
        end
        if (any) begin
            gnt = N'(1) << idx;
        end
    end
endmodule

// File: rtl/taiga_fifo.sv
// Small synchronous FIFO used to hold load tags in issue order.
module taiga_fifo #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign data_out = mem_q[rd_ptr_q];
    assign valid    = (cnt_q != '0);
    assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state; synchronous reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end
endmodule

// File: rtl/rca_lsu_arbiter.sv
// Shares the LSU RCA port among NUM_PORTS requesters: lock handling,
// round-robin issue and in-order load response steering.
module rca_lsu_arbiter
    import rca_lsu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    rca_lsu_arbiter_if.slave  rca,
    output logic              lsu_lock,
    input  logic              lsu_ready,
    output logic [XLEN-1:0]   lsu_rs1,
    output logic [XLEN-1:0]   lsu_rs2,
    output logic [FN3_W-1:0]  lsu_fn3,
    output logic              lsu_load,
    output logic              lsu_store,
    input  logic              lsu_load_complete,
    input  logic [XLEN-1:0]   lsu_load_data,
    output logic              busy
);
    localparam int unsigned PID_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    rca_arb_state_t       state_q, state_d;
    logic [PID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;

    logic [NUM_PORTS-1:0] top_gnt;
    logic [PID_W-1:0]     top_idx;
    logic                 top_any;
    rca_mem_req_t         sel_req;
    logic                 grant_ok;
    logic                 tag_push;
    logic                 tag_pop;
    logic                 tag_valid;
    logic                 tag_full;
    logic [PID_W-1:0]     tag_out;

    rca_rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req (rca.req_valid),
        .ptr (rr_ptr_q),
        .gnt (top_gnt),
        .idx (top_idx),
        .any (top_any)
    );

    taiga_fifo #(.DATA_WIDTH(PID_W), .FIFO_DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .pop      (tag_pop),
        .data_in  (top_idx),
        .data_out (tag_out),
        .valid    (tag_valid),
        .full     (tag_full)
    );

    // Gather the highest-priority port's request.
    always_comb begin
        sel_req.addr  = rca.req_addr[top_idx];
        sel_req.wdata = rca.req_wdata[top_idx];
        sel_req.fn3   = rca.req_fn3[top_idx];
        sel_req.load  = rca.req_load[top_idx];
        sel_req.store = rca.req_store[top_idx];
    end

    // A blocked load at the head of priority stalls the cycle; no skipping to later ports.
    always_comb begin
        grant_ok = (state_q == ACTIVE) && lsu_ready && top_any &&
                   !(sel_req.load && tag_full);
        tag_push = grant_ok && sel_req.load;
        tag_pop  = lsu_load_complete && tag_valid;
    end

    // Zero-latency issue and response paths.
    always_comb begin
        rca.req_ready  = grant_ok ? top_gnt : '0;
        lsu_load       = grant_ok && sel_req.load;
        lsu_store      = grant_ok && sel_req.store;
        lsu_rs1        = grant_ok ? sel_req.addr  : '0;
        lsu_rs2        = grant_ok ? sel_req.wdata : '0;
        lsu_fn3        = grant_ok ? sel_req.fn3   : '0;
        rca.resp_valid = tag_pop ? (NUM_PORTS'(1) << tag_out) : '0;
        rca.resp_data  = tag_pop ? lsu_load_data : '0;
        lsu_lock       = (state_q != IDLE);
        busy           = (state_q != IDLE) || (outstanding_q != '0);
    end

    // Lock sequencing, pointer update and outstanding-load count.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        outstanding_d = outstanding_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
        if (grant_ok) begin
            rr_ptr_d = top_idx;
        end
        unique case (state_q)
            IDLE:    if (|rca.req_valid) state_d = LOCKING;
            LOCKING: if (lsu_ready)      state_d = ACTIVE;
            ACTIVE:  if (!(|rca.req_valid)) state_d = DRAIN;
            DRAIN: begin
                if (|rca.req_valid)              state_d = ACTIVE;
                else if (outstanding_q == '0)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Interface protocol checks.
    a_complete_empty: assert property (@(posedge clk) disable iff (rst)
        lsu_load_complete |-> tag_valid);
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(rca.req_ready));

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port_chk
        a_kind: assert property (@(posedge clk) disable iff (rst)
            rca.req_valid[i] |-> (rca.req_load[i] != rca.req_store[i]));
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (rca.req_valid[i] && !rca.req_ready[i]) |=>
            (rca.req_valid[i] && $stable(rca.req_addr[i]) && $stable(rca.req_wdata[i]) &&
             $stable(rca.req_fn3[i]) && $stable(rca.req_load[i]) && $stable(rca.req_store[i])));
    end
endmodule

// File: tb/tb_rca_lsu_arbiter.sv
// Randomized scoreboard bench for rca_lsu_arbiter.
module tb_rca_lsu_arbiter;
    localparam int NP = 4;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_lock, lsu_ready, lsu_load, lsu_store, lsu_load_complete, busy;
    logic [31:0] lsu_rs1, lsu_rs2, lsu_load_data;
    logic [2:0]  lsu_fn3;

    always #5 clk = ~clk;

    rca_lsu_arbiter_if #(.NUM_PORTS(NP)) rif ();

    rca_lsu_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MO)) dut (
        .clk               (clk),
        .rst               (rst),
        .rca               (rif),
        .lsu_lock          (lsu_lock),
        .lsu_ready         (lsu_ready),
        .lsu_rs1           (lsu_rs1),
        .lsu_rs2           (lsu_rs2),
        .lsu_fn3           (lsu_fn3),
        .lsu_load          (lsu_load),
        .lsu_store         (lsu_store),
        .lsu_load_complete (lsu_load_complete),
        .lsu_load_data     (lsu_load_data),
        .busy              (busy)
    );

    typedef struct { int port; logic [31:0] data; } resp_t;

    int checks = 0;
    int failures = 0;

    // Bench-held requester state
    logic [NP-1:0] pv, pload;
    logic [31:0]   paddr [NP];
    logic [31:0]   pwdata[NP];
    logic [2:0]    pfn3  [NP];

    int  p_req, p_load, p_ready, p_comp;
    bit  stim_on;
    bit  rst_prev = 1'b0;

    logic [31:0] lsu_data_q[$];
    resp_t       exp_resp_q[$];

    // Reference model: lock phase (0 none, 1 waiting, 2 issuing, 3 draining), last grant, loads in flight
    int m_phase, m_rr, m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model comparison for grants, lock and busy
    always @(negedge clk) begin : mon
        int     eg, old_out, p;
        bit     found;
        resp_t  r;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_lock", 32'(lsu_lock), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_ready", 32'(rif.req_ready), 0);
                chk("rst_resp_valid", 32'(rif.resp_valid), 0);
                chk("rst_issue", {30'd0, lsu_load, lsu_store}, 0);
            end
            m_phase = 0; m_rr = 0; m_out = 0;
            exp_resp_q.delete();
            lsu_data_q.delete();
        end else begin
            eg = -1;
            found = 1'b0;
            if (m_phase == 2 && lsu_ready && pv != '0) begin
                for (int i = 1; i <= NP; i++) begin
                    p = (m_rr + i) % NP;
                    if (!found && pv[p]) begin
                        found = 1'b1;
                        eg = p;
                    end
                end
                if (pload[eg] && m_out == MO) eg = -1;
            end
            chk("req_ready", 32'(rif.req_ready), (eg >= 0) ? (32'd1 << eg) : 32'd0);
            chk("lsu_load", 32'(lsu_load), (eg >= 0 && pload[eg]) ? 1 : 0);
            chk("lsu_store", 32'(lsu_store), (eg >= 0 && !pload[eg]) ? 1 : 0);
            chk("lsu_lock", 32'(lsu_lock), (m_phase != 0) ? 1 : 0);
            chk("busy", 32'(busy), (m_phase != 0 || m_out != 0) ? 1 : 0);
            old_out = m_out;
            if (eg >= 0) begin
                chk("lsu_rs1", lsu_rs1, paddr[eg]);
                chk("lsu_fn3", 32'(lsu_fn3), 32'(pfn3[eg]));
                if (!pload[eg]) chk("lsu_rs2", lsu_rs2, pwdata[eg]);
                m_rr = eg;
                if (pload[eg]) begin
                    r.port = eg;
                    r.data = $urandom;
                    lsu_data_q.push_back(r.data);
                    exp_resp_q.push_back(r);
                    m_out++;
                end
            end
            if (lsu_load_complete && m_out > 0) m_out--;
            case (m_phase)
                0: if (pv != '0) m_phase = 1;
                1: if (lsu_ready) m_phase = 2;
                2: if (pv == '0) m_phase = 3;
                default: begin
                    if (pv != '0) m_phase = 2;
                    else if (old_out == 0) m_phase = 0;
                end
            endcase
        end
        rst_prev = rst;
    end

    // Response monitor: every completion must be steered to the port that issued it
    always @(negedge clk) begin : resp_mon
        resp_t r;
        if (!rst && (lsu_load_complete || rif.resp_valid != '0)) begin
            if (exp_resp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got resp_valid %b with nothing outstanding", rif.resp_valid);
            end else begin
                r = exp_resp_q.pop_front();
                chk("resp_valid", 32'(rif.resp_valid), 32'd1 << r.port);
                chk("resp_data", rif.resp_data, r.data);
            end
        end
    end

    task automatic drive_ports();
        rif.req_valid = pv;
        for (int p = 0; p < NP; p++) begin
            rif.req_load[p]  = pload[p];
            rif.req_store[p] = !pload[p];
            rif.req_addr[p]  = paddr[p];
            rif.req_wdata[p] = pwdata[p];
            rif.req_fn3[p]   = pfn3[p];
        end
    endtask

    // One cycle of requester and LSU behaviour
    task automatic step();
        logic [NP-1:0] acc;
        @(negedge clk);
        acc = rif.req_valid & rif.req_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (!pv[p] || acc[p]) begin
                if (stim_on && int'($urandom % 100) < p_req) begin
                    pv[p]     = 1'b1;
                    pload[p]  = int'($urandom % 100) < p_load;
                    paddr[p]  = $urandom;
                    pwdata[p] = $urandom;
                    pfn3[p]   = 3'($urandom);
                end else begin
                    pv[p] = 1'b0;
                end
            end
        end
        drive_ports();
        lsu_ready = lsu_lock && (int'($urandom % 100) < p_ready);
        if (lsu_data_q.size() > 0 && int'($urandom % 100) < p_comp) begin
            lsu_load_complete = 1'b1;
            lsu_load_data     = lsu_data_q.pop_front();
        end else begin
            lsu_load_complete = 1'b0;
            lsu_load_data     = $urandom;
        end
    endtask

    task automatic run_phase(input int n, input int rq, input int ld, input int rdy, input int cmp);
        p_req = rq; p_load = ld; p_ready = rdy; p_comp = cmp;
        stim_on = 1'b1;
        repeat (n) step();
    endtask

    task automatic drain();
        int k;
        stim_on = 1'b0;
        p_ready = 100;
        p_comp  = 100;
        k = 0;
        while ((busy || pv != '0) && k < 300) begin
            step();
            k++;
        end
        checks++;
        if (busy || pv != '0) begin
            failures++;
            $display("FAIL drain_timeout: busy=%b pending=%b", busy, pv);
        end
    endtask

    // Reset in the middle of traffic, with a late completion arriving during reset
    task automatic mid_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        lsu_load_complete = 1'b0;
        @(posedge clk);
        #1;
        pv = '0;
        drive_ports();
        lsu_ready = 1'b0;
        lsu_load_complete = 1'b1;
        lsu_load_data = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        lsu_load_complete = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pv = '0;
        pload = '0;
        for (int p = 0; p < NP; p++) begin
            paddr[p] = '0; pwdata[p] = '0; pfn3[p] = '0;
        end
        drive_ports();
        lsu_ready = 1'b0;
        lsu_load_complete = 1'b0;
        lsu_load_data = '0;
        stim_on = 1'b0;
        p_req = 0; p_load = 0; p_ready = 0; p_comp = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_phase(300, 20, 50, 70, 50);   // sparse mixed traffic
        drain();
        run_phase(200, 100, 0, 100, 0);   // saturated stores: rotation fairness
        drain();
        run_phase(300, 90, 50, 20, 40);   // heavy LSU back-pressure
        drain();
        run_phase(40, 100, 80, 100, 0);   // fill the tag FIFO
        run_phase(150, 100, 80, 100, 30); // full FIFO releasing slowly
        drain();
        run_phase(30, 100, 90, 100, 0);   // build up loads in flight
        mid_reset();
        run_phase(200, 60, 60, 80, 60);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
